// File: rtl/ics_pkg.sv
// Shared definitions for the ICS servo poll scheduler.
//   state_e      : scheduler FSM states
//   ICS_CMD_POS  : top three bits of an ICS position command byte
//   FRAME_LEN    : bytes per command and per reply frame
//   POS_W        : servo position width
package ics_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitRx,
        StReport,
        StNext
    } state_e;

    localparam logic [2:0]  ICS_CMD_POS = 3'b100;
    localparam int unsigned FRAME_LEN   = 3;
    localparam int unsigned POS_W       = 14;

endpackage

// File: rtl/ics_reply_collector.sv
// Collects one 3-byte ICS reply and watches the reply timeout.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart collection (rx count and timeout counter to zero)
//   enable    : high while the scheduler waits for the reply
//   id        : servo ID expected in the reply header
//   rx_data   : reply byte, qualified by the one-cycle strobe rx_valid
//   done      : third byte arrived or timeout reached this cycle
//   err, pos  : result of the last completed reply, held until the next one
module ics_reply_collector
    import ics_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [4:0]       id,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             done,
    output logic             err,
    output logic [POS_W-1:0] pos
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  cnt_q;
    logic [15:0] tmo_q;
    logic [7:0]  b0_q;
    logic [7:0]  b1_q;
    logic [7:0]  b2_q;
    logic        err_q;
    logic        third;
    logic        tmo_hit;

    always_comb begin
        third   = enable && rx_valid && (cnt_q == 2'(FRAME_LEN - 1));
        tmo_hit = enable && (tmo_q == TMO_LAST);
        // A third byte coinciding with the timeout still counts as a reply.
        done    = third || tmo_hit;
        err     = err_q;
        pos     = err_q ? '0 : {b1_q[6:0], b2_q[6:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= '0;
            b0_q  <= '0;
            b1_q  <= '0;
            b2_q  <= '0;
            err_q <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else if (enable) begin
            if (!done) begin
                tmo_q <= tmo_q + 16'd1;
            end
            // Count saturates at 3 so surplus bytes are dropped.
            if (rx_valid && (cnt_q != 2'd3)) begin
                case (cnt_q)
                    2'd0:    b0_q <= rx_data;
                    2'd1:    b1_q <= rx_data;
                    default: b2_q <= rx_data;
                endcase
                cnt_q <= cnt_q + 2'd1;
            end
            if (done) begin
                err_q <= third ? (b0_q != {3'b000, id}) : 1'b1;
            end
        end
    end

endmodule

// File: rtl/ics_poll_scheduler.sv
// Sweeps the ICS bus once per timer tick: for each servo ID in order it sends a
// 3-byte position command, collects the 3-byte reply and reports the result.
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   tick_i                : timer interrupt; rising edge starts a sweep
//   target_pos_i          : packed 14-bit targets, servo n at [14n+13:14n]
//   tx_data_o/valid/ready : command byte stream to the UART (valid/ready)
//   rx_data_i/rx_valid_i  : reply byte strobe from the UART, no backpressure
//   resp_*                : one-cycle reply report (id, position, error)
//   busy_o                : sweep in progress
//   overrun_o             : tick edge arrived during a sweep and was dropped
module ics_poll_scheduler
    import ics_pkg::*;
#(
    parameter int unsigned NUM_SERVO   = 4,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       tick_i,
    input  logic [POS_W*NUM_SERVO-1:0] target_pos_i,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    input  logic [7:0]                 rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       resp_valid_o,
    output logic [4:0]                 resp_id_o,
    output logic [POS_W-1:0]           resp_pos_o,
    output logic                       resp_err_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    state_e           state_q, state_d;
    logic [4:0]       id_q, id_d;
    logic [1:0]       idx_q, idx_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic             tick_q;
    logic             tick_edge;
    logic             clear;
    logic             col_done;
    logic             col_err;
    logic [POS_W-1:0] col_pos;

    ics_reply_collector #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_collector (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .clear    (clear),
        .enable   (state_q == StWaitRx),
        .id       (id_q),
        .rx_data  (rx_data_i),
        .rx_valid (rx_valid_i),
        .done     (col_done),
        .err      (col_err),
        .pos      (col_pos)
    );

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        idx_d        = idx_q;
        tgt_d        = tgt_q;
        clear        = 1'b0;
        tx_valid_o   = 1'b0;
        tx_data_o    = '0;
        resp_valid_o = 1'b0;
        resp_id_o    = '0;
        resp_pos_o   = '0;
        resp_err_o   = 1'b0;
        tick_edge    = tick_i && !tick_q;
        busy_o       = (state_q != StIdle);
        overrun_o    = tick_edge && busy_o;

        unique case (state_q)
            StIdle: begin
                if (tick_edge) begin
                    id_d    = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                tgt_d   = target_pos_i[POS_W*id_q +: POS_W];
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                tx_valid_o = 1'b1;
                case (idx_q)
                    2'd0:    tx_data_o = {ICS_CMD_POS, id_q};
                    2'd1:    tx_data_o = {1'b0, tgt_q[13:7]};
                    default: tx_data_o = {1'b0, tgt_q[6:0]};
                endcase
                if (tx_ready_i) begin
                    if (idx_q == 2'(FRAME_LEN - 1)) begin
                        clear   = 1'b1;
                        state_d = StWaitRx;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StWaitRx: begin
                if (col_done) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                resp_valid_o = 1'b1;
                resp_id_o    = id_q;
                resp_pos_o   = col_pos;
                resp_err_o   = col_err;
                state_d      = StNext;
            end
            StNext: begin
                if (id_q == 5'(NUM_SERVO - 1)) begin
                    state_d = StIdle;
                end else begin
                    id_d    = id_q + 5'd1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            tick_q  <= tick_i;
        end
    end

endmodule

// File: tb/tb_ics_poll_scheduler.sv
// Self-checking bench for ics_poll_scheduler (2 servos, 100-cycle timeout).
// A transaction-level model predicts the command bytes of each sweep and the
// report (id, position, error, cycle) of each reply the responder produces.
module tb_ics_poll_scheduler;

    localparam int NS = 2;
    localparam int TO = 100;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          tick_i;
    logic [27:0]   target_pos_i;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          resp_valid_o;
    logic [4:0]    resp_id_o;
    logic [13:0]   resp_pos_o;
    logic          resp_err_o;
    logic          busy_o;
    logic          overrun_o;

    ics_poll_scheduler #(
        .NUM_SERVO   (NS),
        .TIMEOUT_CYC (TO)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .tick_i       (tick_i),
        .target_pos_i (target_pos_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .resp_valid_o (resp_valid_o),
        .resp_id_o    (resp_id_o),
        .resp_pos_o   (resp_pos_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int id;
        int pos;
        int err;
        int cyc;
    } rep_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          tx_cnt = 0;
    int          ovr_cnt = 0;
    int          edge_cyc = 0;
    int          sweep_base = 0;
    int          busy_clear_cyc = -1;
    int          ready_mode = 0;
    int          ph = 0;
    bit          busy_m = 0;
    bit          tick_prev = 0;
    bit          edge_now;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  exp_b;
    rep_t        er;
    logic [7:0]  txq[$];
    rep_t        repq[$];
    logic [7:0]  tx_log[$];
    rep_t        rep_log[$];
    logic [13:0] tgt[NS];

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            chk("rst_outputs", {tx_valid_o, tx_data_o, resp_valid_o, resp_id_o, resp_pos_o,
                                resp_err_o, busy_o, overrun_o}, 0);
            busy_m = 0;
            busy_clear_cyc = -1;
            prev_stall = 0;
            txq.delete();
            repq.delete();
            tick_prev = 0;
        end else begin
            edge_now = tick_i && !tick_prev;
            chk("busy", busy_o, busy_m);
            chk("overrun", overrun_o, edge_now && busy_m);
            if (overrun_o) ovr_cnt++;
            if (!busy_m) chk("idle_quiet", {tx_valid_o, resp_valid_o}, 0);
            if (prev_stall) begin
                chk("tx_hold_valid", tx_valid_o, 1);
                chk("tx_hold_data", tx_data_o, prev_data);
            end
            if (tx_valid_o && tx_ready_i) begin
                tx_log.push_back(tx_data_o);
                tx_cnt++;
                if (txq.size() == 0) begin
                    fail_now($sformatf("tx_unexpected: byte 0x%0h, none required", tx_data_o));
                end else begin
                    exp_b = txq.pop_front();
                    chk("tx_byte", tx_data_o, exp_b);
                end
            end
            if (resp_valid_o) begin
                rep_log.push_back('{int'(resp_id_o), int'(resp_pos_o), int'(resp_err_o), cyc});
                if (repq.size() == 0) begin
                    fail_now($sformatf("resp_unexpected: id %0d, none required", resp_id_o));
                end else begin
                    er = repq.pop_front();
                    chk("resp_id", resp_id_o, er.id);
                    chk("resp_pos", resp_pos_o, er.pos);
                    chk("resp_err", resp_err_o, er.err);
                    chk("resp_cycle", cyc, er.cyc);
                end
                // Last report: NEXT follows, then idle.
                if (resp_id_o == 5'(NS - 1)) busy_clear_cyc = cyc + 1;
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data = tx_data_o;
            if (edge_now && !busy_m) begin
                busy_m = 1;
                edge_cyc = cyc;
            end else if (cyc == busy_clear_cyc) begin
                busy_m = 0;
                busy_clear_cyc = -1;
            end
            tick_prev = tick_i;
        end
    end

    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            ph++;
            case (ready_mode)
                0: tx_ready_i = 1'b1;
                1: tx_ready_i = (ph % 3 == 0);
                default: tx_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i = b;
        idle(1);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_tx(input int target, output bit ok);
        int n = 0;
        ok = 1;
        while (tx_cnt < target) begin
            idle(1);
            n++;
            if (n > 400) begin
                fail_now($sformatf("tx_wait_timeout: %0d of %0d bytes", tx_cnt, target));
                ok = 0;
                break;
            end
        end
    endtask

    // Modes: 0 good, 1 bad header, 2 silent, 3 last byte on the timeout cycle,
    // 4 last byte one cycle after the timeout.
    task automatic respond(input int id, input int mode, input bit zmsb);
        bit ok;
        int w;
        int r;
        logic [13:0] p;
        logic [7:0] b0, b1, b2;
        wait_tx(sweep_base + 3 * (id + 1), ok);
        if (!ok) return;
        w = cyc;
        p = tgt[id];
        b0 = 8'(id);
        b1 = {zmsb ? 1'b0 : 1'($urandom_range(0, 1)), p[13:7]};
        b2 = {zmsb ? 1'b0 : 1'($urandom_range(0, 1)), p[6:0]};
        case (mode)
            0, 1: begin
                if (mode == 1) b0 = b0 ^ 8'h05;
                idle($urandom_range(0, 4));
                send_rx(b0);
                idle($urandom_range(0, 2));
                send_rx(b1);
                idle($urandom_range(0, 2));
                r = cyc;
                if (mode == 0) repq.push_back('{id, int'(p), 0, r + 1});
                else repq.push_back('{id, 0, 1, r + 1});
                send_rx(b2);
                send_rx(8'($urandom));
            end
            2: repq.push_back('{id, 0, 1, w + TO});
            3: begin
                repq.push_back('{id, int'(p), 0, w + TO});
                send_rx(b0);
                send_rx(b1);
                while (cyc < w + TO - 1) idle(1);
                send_rx(b2);
            end
            default: begin
                repq.push_back('{id, 0, 1, w + TO});
                send_rx(b0);
                send_rx(b1);
                while (cyc < w + TO) idle(1);
                send_rx(b2);
            end
        endcase
    endtask

    task automatic push_frames();
        for (int i = 0; i < NS; i++) begin
            txq.push_back(8'h80 | 8'(i));
            txq.push_back({1'b0, tgt[i][13:7]});
            txq.push_back({1'b0, tgt[i][6:0]});
        end
        target_pos_i = {tgt[1], tgt[0]};
    endtask

    task automatic sweep(input int m0, input int m1, input int hold, input int ovr_at,
                         input bit zmsb);
        int n = 0;
        tx_log.delete();
        rep_log.delete();
        sweep_base = tx_cnt;
        push_frames();
        fork
            begin
                tick_i = 1'b1;
                idle(hold);
                tick_i = 1'b0;
                if (ovr_at > 0) begin
                    idle(ovr_at);
                    tick_i = 1'b1;
                    idle(1);
                    tick_i = 1'b0;
                end
            end
            begin
                respond(0, m0, zmsb);
                respond(1, m1, zmsb);
            end
        join
        while (busy_m && n < 500) begin
            idle(1);
            n++;
        end
        if (n >= 500) fail_now("sweep_end_timeout");
        idle(2);
        chk("txq_drained", txq.size(), 0);
        chk("repq_drained", repq.size(), 0);
    endtask

    initial begin
        logic [7:0] lit_tx[6];
        int o0;
        int r;
        int md[2];
        lit_tx = '{8'h80, 8'h3A, 8'h4C, 8'h81, 8'h1F, 8'h20};
        ap_rst = 1'b1;
        tick_i = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i = '0;
        target_pos_i = '0;
        idle(3);
        ap_rst = 1'b0;
        idle(3);

        // Known targets and replies.
        tgt[0] = 14'h1D4C;
        tgt[1] = 14'h0FA0;
        sweep(0, 0, 1, 0, 1);
        chk("lit_tx_count", tx_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("lit_tx_%0d", i), tx_log[i], lit_tx[i]);
        chk("lit_rep_count", rep_log.size(), 2);
        chk("lit_rep0", {rep_log[0].id, rep_log[0].pos, rep_log[0].err}, {32'd0, 32'h1D4C, 32'd0});
        chk("lit_rep1", {rep_log[1].id, rep_log[1].pos, rep_log[1].err}, {32'd1, 32'h0FA0, 32'd0});

        // Silent servo 0: timeout report, sweep continues.
        tgt[0] = 14'($urandom);
        tgt[1] = 14'($urandom);
        sweep(2, 0, 1, 0, 0);
        chk("lit_tmo_count", rep_log.size(), 2);
        chk("lit_tmo_cycle", rep_log[0].cyc, edge_cyc + 105);
        chk("lit_tmo_rep0", {rep_log[0].id, rep_log[0].pos, rep_log[0].err}, {32'd0, 32'd0, 32'd1});
        chk("lit_tmo_next_id", rep_log[1].id, 1);

        // Bad header 0x05 on servo 0.
        sweep(1, 0, 1, 0, 0);
        chk("lit_badhdr", {rep_log[0].pos, rep_log[0].err}, {32'd0, 32'd1});

        // Ready asserted one cycle in three.
        ready_mode = 1;
        sweep(0, 0, 1, 0, 0);
        chk("slow_ready_tx_count", tx_log.size(), 6);
        ready_mode = 0;

        // Second tick mid-sweep is dropped.
        o0 = ovr_cnt;
        sweep(0, 0, 1, 8, 0);
        idle(30);
        chk("lit_overrun_pulses", ovr_cnt - o0, 1);
        chk("lit_overrun_reports", rep_log.size(), 2);

        // Tick held high for 50 cycles starts one sweep.
        o0 = ovr_cnt;
        sweep(0, 0, 50, 0, 0);
        idle(10);
        chk("lit_hold_overrun", ovr_cnt - o0, 0);
        chk("lit_hold_reports", rep_log.size(), 2);

        // Timeout boundary: byte on the timeout cycle wins; one cycle later loses.
        sweep(3, 4, 1, 0, 0);
        chk("lit_bound_errs", {rep_log[0].err, rep_log[1].err}, {32'd0, 32'd1});

        // Reset during command byte 1.
        sweep_base = tx_cnt;
        push_frames();
        tick_i = 1'b1;
        idle(1);
        tick_i = 1'b0;
        begin
            bit ok;
            wait_tx(sweep_base + 1, ok);
        end
        ap_rst = 1'b1;
        #1;
        chk("lit_rst_async", {tx_valid_o, tx_data_o, resp_valid_o, resp_id_o, resp_pos_o,
                              resp_err_o, busy_o, overrun_o}, 0);
        idle(3);
        ap_rst = 1'b0;
        idle(20);
        sweep(0, 0, 1, 0, 0);
        chk("lit_post_rst_first", tx_log[0], 8'h80);

        // Randomized sweeps.
        for (int k = 0; k < 8; k++) begin
            ready_mode = $urandom_range(0, 2);
            tgt[0] = 14'($urandom);
            tgt[1] = 14'($urandom);
            for (int j = 0; j < 2; j++) begin
                r = $urandom_range(0, 9);
                md[j] = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
            end
            sweep(md[0], md[1], $urandom_range(1, 3), 0, 0);
            idle($urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
